// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing: pixel-rate divider, h/v counters, registered syncs,
// a visible-area flag and a one-clock frame tick at the start of vertical blanking.
module vga_sync_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       pixel_tick,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_DISP     = 10'(H_DISPLAY);
   localparam logic [9:0] V_DISP     = 10'(V_DISPLAY);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_tick_q, pix_tick_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic             frame_tick_q, frame_tick_d;

   // Next-state logic; the sync/video/frame flags decode the next counts so they
   // switch on the very edge the counters do.
   always_comb begin
      div_d        = div_q;
      pix_tick_d   = 1'b0;
      h_d          = h_q;
      v_d          = v_q;
      hsync_d      = 1'b1;
      vsync_d      = 1'b1;
      video_on_d   = 1'b0;
      frame_tick_d = 1'b0;
      if (rst) begin
         div_d        = '0;
         pix_tick_d   = 1'b0;
         h_d          = 10'd0;
         v_d          = 10'd0;
         hsync_d      = 1'b1;
         vsync_d      = 1'b1;
         video_on_d   = 1'b0;
         frame_tick_d = 1'b0;
      end else begin
         pix_tick_d = (div_q == DIV_LAST);
         if (div_q == DIV_LAST) begin
            div_d = '0;
         end else begin
            div_d = div_q + 1'b1;
         end

         if (pix_tick_q) begin
            if (h_q == H_LAST) begin
               h_d = 10'd0;
               if (v_q == V_LAST) begin
                  v_d = 10'd0;
               end else begin
                  v_d = v_q + 10'd1;
               end
            end else begin
               h_d = h_q + 10'd1;
            end
         end else begin
            h_d = h_q;
            v_d = v_q;
         end

         hsync_d    = !((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END));
         vsync_d    = !((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END));
         video_on_d = (h_d < H_DISP) && (v_d < V_DISP);
         // Only an advancing edge can land on (0,V_DISPLAY), so this fires once per frame.
         frame_tick_d = pix_tick_q && (h_d == 10'd0) && (v_d == V_DISP);
      end
   end

   // State and output registers; reset is folded into the next-state logic.
   always_ff @(posedge clk) begin
      div_q        <= div_d;
      pix_tick_q   <= pix_tick_d;
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
   end

   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign video_on   = video_on_q;
   assign pixel_x    = h_q;
   assign pixel_y    = v_q;
   assign pixel_tick = pix_tick_q;
   assign frame_tick = frame_tick_q;

endmodule
